// File: rtl/bsg_acm_pkg.sv
// Shared definitions for the ACM engine client side: arbiter state
// encoding, engine word width and the default per-job word counts
// derived from the board size.
package bsg_acm_pkg;

  // Width of every word exchanged with the ACM engine.
  localparam int acm_word_width_lp = 64;

  // Default board is board_width x board_width cells, one bit per cell.
  localparam int acm_board_width_lp = 16;

  // Board cells packed into engine words (rounded up to whole words).
  localparam int acm_cell_words_lp =
    (acm_board_width_lp * acm_board_width_lp + acm_word_width_lp - 1) / acm_word_width_lp;

  // A job carries all cell words plus one frames word; the result is the board.
  localparam int acm_in_words_lp  = acm_cell_words_lp + 1;
  localparam int acm_out_words_lp = acm_cell_words_lp;

  // Arbiter job phases.
  typedef enum logic [1:0] {
    ACM_IDLE = 2'd0,
    ACM_SEND = 2'd1,
    ACM_RECV = 2'd2
  } acm_arb_state_e;

  // Larger of two integers, used for sizing shared counters.
  function automatic int acm_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_acm_rr_pick.sv
// Combinational round-robin priority selector.
// Searches req_i starting at last_i+1 and wrapping modulo num_p; the first
// set bit wins. found_o is low when no bit of req_i is set, in which case
// winner_o is 0. Used by the ACM client arbiter and reusable elsewhere.
module bsg_acm_rr_pick
  import bsg_acm_pkg::*;
#(
  parameter  int num_p    = 4,
  localparam int idx_w_lp = (num_p > 1) ? $clog2(num_p) : 1
) (
  input  logic [num_p-1:0]    req_i,
  input  logic [idx_w_lp-1:0] last_i,
  output logic [idx_w_lp-1:0] winner_o,
  output logic                found_o
);

  // Scan num_p slots after last_i; last_i itself is visited last.
  always_comb begin
    logic [idx_w_lp-1:0] idx_v;
    winner_o = '0;
    found_o  = 1'b0;
    idx_v    = '0;
    for (int i = 1; i <= num_p; i++) begin
      idx_v = idx_w_lp'((int'(last_i) + i) % num_p);
      if (!found_o && req_i[idx_v]) begin
        found_o  = 1'b1;
        winner_o = idx_v;
      end
    end
  end

endmodule

// File: rtl/bsg_acm_client_arbiter.sv
// Shares one ACM encryption engine among num_clients_p requesters.
// Round-robin arbitration at job granularity: a granted client streams
// in_words_p words to the engine, then out_words_p result words are routed
// back to that same client before the next grant.
// Optional performance counters are built when BSG_ACM_ARB_PERF_EN is
// defined (jobs_done_o, stall_cycles_o).
//
// Handshake semantics on every channel: a word moves in a cycle where the
// producer's valid and the consumer's ready (or yumi) are both high at the
// rising clock edge. Valid never depends on ready in this block; ready/yumi
// outputs are combinational from state plus the downstream ready/yumi and
// never from the requesting client's own valid.
module bsg_acm_client_arbiter
  import bsg_acm_pkg::*;
#(
  parameter  int num_clients_p = 4,
  parameter  int in_words_p    = acm_in_words_lp,
  parameter  int out_words_p   = acm_out_words_lp,
  localparam int id_w_lp       = $clog2(num_clients_p),
  localparam int cnt_max_lp    = acm_max(in_words_p, out_words_p),
  localparam int cnt_w_lp      = $clog2(cnt_max_lp + 1)
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [num_clients_p*acm_word_width_lp-1:0]  client_data_i,
  input  logic [num_clients_p-1:0]                    client_v_i,
  output logic [num_clients_p-1:0]                    client_ready_o,
  output logic [acm_word_width_lp-1:0]                client_data_o,
  output logic [num_clients_p-1:0]                    client_v_o,
  input  logic [num_clients_p-1:0]                    client_yumi_i,
  output logic [acm_word_width_lp-1:0]                engine_data_o,
  output logic                                        engine_v_o,
  input  logic                                        engine_ready_i,
  input  logic [acm_word_width_lp-1:0]                engine_data_i,
  input  logic                                        engine_v_i,
  output logic                                        engine_yumi_o,
  output logic                                        busy_o,
  output logic [id_w_lp-1:0]                          grant_id_o,
  output acm_arb_state_e                              state_o
`ifdef BSG_ACM_ARB_PERF_EN
  ,
  output logic [31:0]                                 jobs_done_o,
  output logic [31:0]                                 stall_cycles_o
`endif
);

  localparam logic [cnt_w_lp-1:0] in_last_lp     = cnt_w_lp'(in_words_p - 1);
  localparam logic [cnt_w_lp-1:0] out_last_lp    = cnt_w_lp'(out_words_p - 1);
  localparam logic [id_w_lp-1:0]  last_init_lp   = id_w_lp'(num_clients_p - 1);

  acm_arb_state_e              state_q, state_d;
  logic [id_w_lp-1:0]          grant_q, grant_d;
  logic [id_w_lp-1:0]          last_grant_q, last_grant_d;
  logic [cnt_w_lp-1:0]         cnt_q, cnt_d;

  logic [acm_word_width_lp-1:0] client_words [num_clients_p];
  logic [id_w_lp-1:0]           pick_id;
  logic                         pick_found;
  logic                         send_hs;
  logic                         recv_hs;

  // Unpack the flat request bus into one word per client.
  for (genvar c = 0; c < num_clients_p; c++) begin : g_slice
    assign client_words[c] = client_data_i[c*acm_word_width_lp +: acm_word_width_lp];
  end

  bsg_acm_rr_pick #(
    .num_p    (num_clients_p)
  ) u_pick (
    .req_i    (client_v_i),
    .last_i   (last_grant_q),
    .winner_o (pick_id),
    .found_o  (pick_found)
  );

  // Route handshakes between the granted client and the engine; everything
  // else is held at zero so non-granted clients never see ready or valid.
  always_comb begin
    client_ready_o = '0;
    client_v_o     = '0;
    client_data_o  = '0;
    engine_data_o  = '0;
    engine_v_o     = 1'b0;
    engine_yumi_o  = 1'b0;
    send_hs        = 1'b0;
    recv_hs        = 1'b0;
    case (state_q)
      ACM_SEND: begin
        engine_v_o              = client_v_i[grant_q];
        engine_data_o           = client_words[grant_q];
        client_ready_o[grant_q] = engine_ready_i;
        send_hs                 = client_v_i[grant_q] & engine_ready_i;
      end
      ACM_RECV: begin
        client_v_o[grant_q] = engine_v_i;
        client_data_o       = engine_data_i;
        engine_yumi_o       = engine_v_i & client_yumi_i[grant_q];
        recv_hs             = engine_v_i & client_yumi_i[grant_q];
      end
      default: begin
      end
    endcase
  end

  // Next-state: grant in IDLE, count words in SEND and RECV, release the
  // grant (and remember it for fairness) after the last result word.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      ACM_IDLE: begin
        if (pick_found) begin
          grant_d = pick_id;
          state_d = ACM_SEND;
        end
      end
      ACM_SEND: begin
        if (send_hs) begin
          if (cnt_q == in_last_lp) begin
            cnt_d   = '0;
            state_d = ACM_RECV;
          end else begin
            cnt_d = cnt_q + cnt_w_lp'(1);
          end
        end
      end
      ACM_RECV: begin
        if (recv_hs) begin
          if (cnt_q == out_last_lp) begin
            cnt_d        = '0;
            last_grant_d = grant_q;
            state_d      = ACM_IDLE;
          end else begin
            cnt_d = cnt_q + cnt_w_lp'(1);
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ACM_IDLE;
      end
    endcase
  end

  // State register; reset aborts any job and gives client 0 top priority.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ACM_IDLE;
      grant_q      <= '0;
      last_grant_q <= last_init_lp;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign busy_o     = (state_q != ACM_IDLE);
  assign grant_id_o = grant_q;
  assign state_o    = state_q;

`ifdef BSG_ACM_ARB_PERF_EN
  logic [31:0] jobs_done_q, jobs_done_d;
  logic [31:0] stall_q, stall_d;
  logic        job_end;
  logic        stall_cyc;

  assign job_end   = (state_q == ACM_RECV) && recv_hs && (cnt_q == out_last_lp);
  assign stall_cyc = ((state_q == ACM_SEND) && !send_hs) ||
                     ((state_q == ACM_RECV) && !recv_hs);

  // Saturating job and stall counters.
  always_comb begin
    jobs_done_d = jobs_done_q;
    stall_d     = stall_q;
    if (job_end && (jobs_done_q != 32'hFFFF_FFFF)) begin
      jobs_done_d = jobs_done_q + 32'd1;
    end
    if (stall_cyc && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Performance counter registers, cleared by reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      jobs_done_q <= '0;
      stall_q     <= '0;
    end else begin
      jobs_done_q <= jobs_done_d;
      stall_q     <= stall_d;
    end
  end

  assign jobs_done_o    = jobs_done_q;
  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_bsg_acm_client_arbiter.sv
// Directed bench for bsg_acm_client_arbiter (4 clients, 5 words in, 4 out).
// Inputs change 2 time units after each rising edge; outputs are sampled
// 1 time unit later, well away from the next edge.
module tb_bsg_acm_client_arbiter;
  import bsg_acm_pkg::*;

  localparam int nc    = 4;
  localparam int w     = 64;
  localparam int in_w  = 5;
  localparam int out_w = 4;

  logic              clk_i   = 1'b0;
  logic              reset_i = 1'b0;
  logic [nc*w-1:0]   client_data_i;
  logic [nc-1:0]     client_v_i      = '0;
  logic [nc-1:0]     client_ready_o;
  logic [w-1:0]      client_data_o;
  logic [nc-1:0]     client_v_o;
  logic [nc-1:0]     client_yumi_i   = '0;
  logic [w-1:0]      engine_data_o;
  logic              engine_v_o;
  logic              engine_ready_i  = 1'b0;
  logic [w-1:0]      engine_data_i   = '0;
  logic              engine_v_i      = 1'b0;
  logic              engine_yumi_o;
  logic              busy_o;
  logic [1:0]        grant_id_o;
  acm_arb_state_e    state_o;
`ifdef BSG_ACM_ARB_PERF_EN
  logic [31:0]       jobs_done_o;
  logic [31:0]       stall_cycles_o;
`endif

  logic [w-1:0]      cw [nc];
  logic [w-1:0]      exp_q [$];
  int                n_checks  = 0;
  int                n_errors  = 0;
  int                exp_jobs  = 0;
  int                exp_stall = 0;

  for (genvar g = 0; g < nc; g++) begin : g_cw
    assign client_data_i[g*w +: w] = cw[g];
  end

  bsg_acm_client_arbiter #(
    .num_clients_p (nc),
    .in_words_p    (in_w),
    .out_words_p   (out_w)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .client_data_i  (client_data_i),
    .client_v_i     (client_v_i),
    .client_ready_o (client_ready_o),
    .client_data_o  (client_data_o),
    .client_v_o     (client_v_o),
    .client_yumi_i  (client_yumi_i),
    .engine_data_o  (engine_data_o),
    .engine_v_o     (engine_v_o),
    .engine_ready_i (engine_ready_i),
    .engine_data_i  (engine_data_i),
    .engine_v_i     (engine_v_i),
    .engine_yumi_o  (engine_yumi_o),
    .busy_o         (busy_o),
    .grant_id_o     (grant_id_o),
    .state_o        (state_o)
`ifdef BSG_ACM_ARB_PERF_EN
    ,
    .jobs_done_o    (jobs_done_o),
    .stall_cycles_o (stall_cycles_o)
`endif
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  function automatic logic [nc-1:0] onehot(input int c);
    return 4'b0001 << c;
  endfunction

  task automatic check_perf(input string tag);
`ifdef BSG_ACM_ARB_PERF_EN
    check({tag, "_jobs"}, 64'(jobs_done_o), 64'(exp_jobs));
    check({tag, "_stall"}, 64'(stall_cycles_o), 64'(exp_stall));
`else
    if (tag.len() == 0) $display("empty perf tag");
`endif
  endtask

  // Asynchronous reset with busy inputs; every output must read zero at once.
  task automatic apply_reset();
    exp_jobs  = 0;
    exp_stall = 0;
    exp_q.delete();
    client_v_i     = '1;
    client_yumi_i  = '1;
    engine_v_i     = 1'b1;
    engine_ready_i = 1'b1;
    engine_data_i  = 64'hFFFF_0000_1234_5678;
    reset_i        = 1'b1;
    #1;
    check("rst_ready",  64'(client_ready_o), 64'h0);
    check("rst_cv",     64'(client_v_o), 64'h0);
    check("rst_cdata",  client_data_o, 64'h0);
    check("rst_edata",  engine_data_o, 64'h0);
    check("rst_ev",     64'(engine_v_o), 64'h0);
    check("rst_yumi",   64'(engine_yumi_o), 64'h0);
    check("rst_busy",   64'(busy_o), 64'h0);
    check("rst_grant",  64'(grant_id_o), 64'h0);
    check("rst_state",  64'(state_o), 64'(ACM_IDLE));
    check_perf("rst");
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    reset_i        = 1'b0;
    client_v_i     = '0;
    client_yumi_i  = '0;
    engine_v_i     = 1'b0;
    engine_ready_i = 1'b0;
    engine_data_i  = '0;
    #1;
    check("rst_rel_state", 64'(state_o), 64'(ACM_IDLE));
  endtask

  // One IDLE cycle with requests present: nothing transfers, then grant.
  task automatic grant_cycle(input logic [nc-1:0] req, input int exp_c);
    client_v_i     = req;
    engine_ready_i = 1'b1;
    #1;
    check("gnt_ready", 64'(client_ready_o), 64'h0);
    check("gnt_ev",    64'(engine_v_o), 64'h0);
    check("gnt_busy",  64'(busy_o), 64'h0);
    check("gnt_state", 64'(state_o), 64'(ACM_IDLE));
    tick();
    #1;
    check("gnt_id",    64'(grant_id_o), 64'(exp_c));
    check("gnt_send",  64'(state_o), 64'(ACM_SEND));
  endtask

  // Drive in_w words from client c; engine ready follows rdy_pat[cyc%4].
  task automatic send_job(input int c, input logic [63:0] base, input logic [3:0] rdy_pat,
                          input logic [nc-1:0] others);
    int sent = 0;
    int cyc  = 0;
    logic [63:0] exp;
    for (int i = 0; i < in_w; i++) exp_q.push_back(base + 64'(i));
    while (sent < in_w && cyc < 40) begin
      client_v_i     = onehot(c) | others;
      cw[c[1:0]]     = base + 64'(sent);
      engine_ready_i = rdy_pat[cyc % 4];
      #1;
      check("snd_ev",    64'(engine_v_o), 64'h1);
      check("snd_ready", 64'(client_ready_o), engine_ready_i ? 64'(onehot(c)) : 64'h0);
      check("snd_state", 64'(state_o), 64'(ACM_SEND));
      if (engine_ready_i) begin
        exp = exp_q.pop_front();
        check("snd_data", engine_data_o, exp);
        sent++;
      end else begin
        exp_stall++;
      end
      tick();
      cyc++;
    end
    client_v_i     = others;
    engine_ready_i = 1'b0;
    #1;
    check("snd_to_recv", 64'(state_o), 64'(ACM_RECV));
  endtask

  // Return out_w results to client c; ev_pat/y_pat drive engine valid and
  // the granted client's yumi, spur adds yumi from other clients.
  task automatic recv_job(input int c, input logic [63:0] base, input logic [7:0] ev_pat,
                          input logic [7:0] y_pat, input logic [nc-1:0] spur);
    int got = 0;
    int cyc = 0;
    while (got < out_w && cyc < 40) begin
      engine_v_i    = ev_pat[cyc % 8];
      engine_data_i = base + 64'(got);
      client_yumi_i = (y_pat[cyc % 8] ? onehot(c) : '0) | spur;
      #1;
      check("rcv_cv",   64'(client_v_o), engine_v_i ? 64'(onehot(c)) : 64'h0);
      check("rcv_yumi", 64'(engine_yumi_o), 64'(engine_v_i & y_pat[cyc % 8]));
      check("rcv_busy", 64'(busy_o), 64'h1);
      if (engine_v_i) check("rcv_data", client_data_o, base + 64'(got));
      if (engine_v_i && y_pat[cyc % 8]) got++;
      else exp_stall++;
      tick();
      cyc++;
    end
    engine_v_i    = 1'b0;
    engine_data_i = '0;
    client_yumi_i = '0;
    exp_jobs++;
    #1;
    check("rcv_idle",  64'(state_o), 64'(ACM_IDLE));
    check("rcv_nbusy", 64'(busy_o), 64'h0);
    check("rcv_gid",   64'(grant_id_o), 64'(c));
  endtask

  initial begin
    for (int i = 0; i < nc; i++) cw[i] = '0;
    #1;
    apply_reset();

    // Single job from client 2.
    grant_cycle(4'b0100, 2);
    send_job(2, 64'h1, 4'b1111, 4'b0000);
    recv_job(2, 64'hA, 8'hFF, 8'hFF, 4'b0000);
    check_perf("single");

    // Isolation: client 3 raises 0xDEAD while client 1 owns the engine;
    // client 0 issues spurious yumi and engine valid has a gap.
    cw[3] = 64'hDEAD;
    grant_cycle(4'b0010, 1);
    send_job(1, 64'h100, 4'b1111, 4'b1000);
    recv_job(1, 64'h200, 8'hFD, 8'hFE, 4'b0001);
    cw[0] = 64'hBEEF;
    grant_cycle(4'b1001, 3);
    send_job(3, 64'h300, 4'b1111, 4'b0001);
    recv_job(3, 64'h400, 8'hFF, 8'hFF, 4'b0000);
    grant_cycle(4'b0011, 0);

    // Backpressure on both channels; client 1 requests throughout.
    cw[1] = 64'h5A5A;
    send_job(0, 64'h500, 4'b1001, 4'b0010);
    recv_job(0, 64'h600, 8'hFF, 8'b1111_0001, 4'b0000);
    check_perf("bp");

    // Held request from client 1 wins next; reset after 2 of 4 results.
    grant_cycle(4'b0010, 1);
    send_job(1, 64'h700, 4'b1111, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      engine_v_i    = 1'b1;
      engine_data_i = 64'h800 + 64'(i);
      client_yumi_i = onehot(1);
      #1;
      check("part_yumi", 64'(engine_yumi_o), 64'h1);
      tick();
    end
    #2;
    apply_reset();

    // Fairness from a fresh reset: all four request continuously.
    for (int i = 0; i < nc; i++) cw[i] = 64'hBAD0 + 64'(i);
    for (int j = 0; j < 8; j++) begin
      grant_cycle(4'hF, j % 4);
      send_job(j % 4, 64'h1_0000 * 64'(j + 1), 4'b1111, 4'hF & ~onehot(j % 4));
      recv_job(j % 4, 64'hF000 + 64'(j * 16), 8'hFF, 8'hFF, 4'b0000);
    end
    check_perf("fair");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bsg_acm_client_arbiter.md
Name: bsg_acm_client_arbiter

Overview:
- Shares one bsg_acm encryption engine among num_clients_p independent requesters.
- Each requester sends a job as a 64-bit word stream: board cells plus a frames word.
- Arbitration is round-robin at job granularity. One job is in flight at a time: all input words of the granted client are forwarded, then all result words are routed back to the same client.
- Sits between the SoC-side client streams and the engine's data_i/v_i/ready_o and data_o/v_o/yumi_i channels.

Parameters:
- num_clients_p, 4, number of requesters (>=2).
- in_words_p, 5, 64-bit words per job sent to the engine (e.g. 4 cell words + 1 frames word for a 16x16 board).
- out_words_p, 4, 64-bit result words per job returned by the engine.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- client_data_i  in  num_clients_p*64  request word per client; client c occupies bits [64c+63:64c].
- client_v_i  in  num_clients_p  request word valid per client.
- client_ready_o  out  num_clients_p  request word accepted (valid-ready).
- client_data_o  out  64  result word, broadcast to all clients.
- client_v_o  out  num_clients_p  result valid; one-hot or zero.
- client_yumi_i  in  num_clients_p  result consumed.
- engine_data_o  out  64  word to the engine.
- engine_v_o  out  1  word to the engine is valid.
- engine_ready_i  in  1  engine accepts the word.
- engine_data_i  in  64  result word from the engine.
- engine_v_i  in  1  result word from the engine is valid.
- engine_yumi_o  out  1  result word consumed.
- busy_o  out  1  a job is granted (state is not IDLE).
- grant_id_o  out  clog2(num_clients_p)  index of the current or last granted client.

Behaviour:
- Reset: asynchronous, active-high.
  - state=IDLE, last_grant=num_clients_p-1 (so client 0 has first priority), grant_id_o=0, word counter=0.
  - All valid/ready/yumi outputs are 0; busy_o=0; data outputs are 0.
- State machine: IDLE -> SEND -> RECV -> IDLE.
- IDLE:
  - When any client_v_i bit is set, select the first requesting client searching from last_grant+1 upward, wrapping modulo num_clients_p.
  - Register the winner into grant_id_o; next state is SEND.
  - No word is transferred in the grant cycle, so arbitration latency is exactly 1 cycle.
  - With no requests, remain in IDLE.
- SEND:
  - engine_v_o = client_v_i[grant].
  - engine_data_o = the granted client's slice of client_data_i.
  - client_ready_o[grant] = engine_ready_i; all other ready bits are 0.
  - Count handshakes (v & ready). When the in_words_p-th handshake occurs, clear the counter and go to RECV in the next cycle.
  - Gaps or withdrawal of the granted client's valid stall the job. No timeout exists; other clients wait.
- RECV:
  - client_v_o[grant] = engine_v_i; client_data_o = engine_data_i.
  - engine_yumi_o = engine_v_i & client_yumi_i[grant].
  - yumi seen on a non-granted client, or while engine_v_i is low, is ignored.
  - When the out_words_p-th transfer occurs, set last_grant = grant, clear the counter and go to IDLE.
- All handshake outputs are combinational from state plus inputs. The paths are ready->ready and v->v, with no path from a client's valid to its own ready.
- Counter width: clog2(max(in_words_p,out_words_p)+1). The counter never exceeds its terminal value.
- Non-granted clients see ready=0 and v=0 for the whole job, even when they assert valid mid-job.
- Reset mid-job aborts the job. The engine shares reset_i, so no partial job survives. After reset, client 0 again has top priority.
- Simultaneous final SEND handshake and a new client request: the request is held until the next IDLE.

Optional Feature:
- Macro: BSG_ACM_ARB_PERF_EN.
- When defined:
  - Adds output jobs_done_o [31:0], incremented on each RECV->IDLE transition, saturating at 2^32-1.
  - Adds output stall_cycles_o [31:0], incremented on each SEND/RECV cycle without a handshake, saturating.
  - Both counters are cleared by reset.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package bsg_acm_pkg holds:
  - the state enum (IDLE, SEND, RECV), 2 bits;
  - the word width constant (64);
  - the default word counts derived from board_width.
- One sub-module: bsg_acm_rr_pick, a combinational round-robin priority selector taking request vector and last_grant, and producing winner index and found flag. It is reusable by the other ACM blocks.

Test Plan:
- Single job: client 2 sends words 0x1..0x5 with engine_ready_i=1, then the engine returns 0xA..0xD with yumi held → engine sees 0x1..0x5 in order, client_v_o=0100 for 4 cycles, busy_o drops 1 cycle after the 4th yumi, grant_id_o=2.
- Fairness: all 4 clients request continuously for 8 jobs → grant order 0,1,2,3,0,1,2,3, and no client receives another client's words.
- Backpressure: engine_ready_i toggles 1,0,0,1 and client_yumi_i is low for 3 cycles → no words are lost or duplicated, the counter ends at exactly 5 in / 4 out, and stall_cycles_o grows by the idle count when BSG_ACM_ARB_PERF_EN is set.
- Isolation: while client 1 is mid-SEND, client 3 asserts v with data 0xDEAD → client_ready_o[3]=0 until client 1's RECV completes, then client 3 is granted next.
- Reset mid-RECV after 2 of 4 results: assert reset_i asynchronously → all outputs are 0 immediately, state is IDLE, the next grant goes to client 0, and jobs_done_o=0.
- Spurious yumi: client 0 asserts yumi during client 1's RECV → engine_yumi_o stays low and the result is routed only to client 1.
